// File: rtl/wfg_drive_spi_if.sv
// Sample stream from the stimulus stage into the SPI drive block.
interface wfg_drive_spi_if;
  localparam int unsigned DATA_W = 18;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/wfg_drive_spi.sv
// SPI (CPHA=0) serialiser for DAC samples, one-word holding buffer, started by sync pulse.
module wfg_drive_spi #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  wfg_drive_spi_if.slave   axis,
  input  logic             wfg_sync_i,
  input  logic             ctrl_en_q_i,
  input  logic             ctrl_cpol_q_i,
  input  logic             ctrl_lsbfirst_q_i,
  input  logic             ctrl_sspol_q_i,
  input  logic [1:0]       ctrl_dff_q_i,
  input  logic [DIV_W-1:0] clkcfg_div_q_i,
  output logic             spi_sclk_o,
  output logic             spi_cs_o,
  output logic             spi_sdo_o,
  output logic             busy_o,
  output logic             underrun_o
);

  localparam int unsigned DATA_W = 18;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HALF_W-1:0]  half_q, half_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [WORD_W-1:0]  hold_data_q, hold_data_d;
  logic               hold_valid_q, hold_valid_d;
  logic               cpol_q, cpol_d;
  logic               lsb_q, lsb_d;
  logic [1:0]         dff_q, dff_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               sdo_q, sdo_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;

  logic               accept_c;
  logic               period_end_c;
  logic               last_half_c;
  logic [4:0]         align_c;
  logic [WORD_W-1:0]  load_word_c;

  // Holding register is writable whenever enabled and empty.
  assign axis.tready  = ctrl_en_q_i & ~hold_valid_q;
  assign accept_c     = axis.tvalid & axis.tready;
  assign period_end_c = (div_cnt_q == div_q);
  // Last half-period index is 2N-1 = {dff, 4'b1111}.
  assign last_half_c  = (half_q == {dff_q, 4'b1111});
  // MSB-first words are left-justified so the shift-out bit is always bit 31.
  assign align_c      = {~ctrl_dff_q_i, 3'b000};
  assign load_word_c  = ctrl_lsbfirst_q_i ? hold_data_q : (hold_data_q << align_c);

  // Next-state, datapath and next-output logic; outputs are registered from the _d values.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    div_d        = div_q;
    half_d       = half_q;
    shreg_d      = shreg_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    cpol_d       = cpol_q;
    lsb_d        = lsb_q;
    dff_d        = dff_q;
    sclk_d       = sclk_q;
    cs_d         = cs_q;
    sdo_d        = sdo_q;
    busy_d       = busy_q;
    underrun_d   = 1'b0;

    if (accept_c) begin
      hold_valid_d = 1'b1;
      hold_data_d  = {{(WORD_W-DATA_W){axis.tdata[DATA_W-1]}}, axis.tdata};
    end

    if (!ctrl_en_q_i) begin
      state_d      = ST_IDLE;
      hold_valid_d = 1'b0;
      cs_d         = ~ctrl_sspol_q_i;
      sclk_d       = ctrl_cpol_q_i;
      sdo_d        = 1'b0;
      busy_d       = 1'b0;
      div_cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cs_d   = ~ctrl_sspol_q_i;
          sclk_d = ctrl_cpol_q_i;
          sdo_d  = 1'b0;
          busy_d = 1'b0;
          if (wfg_sync_i) begin
            if (hold_valid_q) begin
              cpol_d       = ctrl_cpol_q_i;
              lsb_d        = ctrl_lsbfirst_q_i;
              dff_d        = ctrl_dff_q_i;
              div_d        = clkcfg_div_q_i;
              shreg_d      = load_word_c;
              hold_valid_d = 1'b0;
              div_cnt_d    = '0;
              state_d      = ST_CS_SETUP;
              cs_d         = ctrl_sspol_q_i;
              sdo_d        = ctrl_lsbfirst_q_i ? load_word_c[0] : load_word_c[WORD_W-1];
              busy_d       = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end

        ST_CS_SETUP: begin
          cs_d   = ctrl_sspol_q_i;
          busy_d = 1'b1;
          if (period_end_c) begin
            div_cnt_d = '0;
            half_d    = '0;
            sclk_d    = ~cpol_q;
            state_d   = ST_SHIFT;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end

        ST_SHIFT: begin
          cs_d   = ctrl_sspol_q_i;
          busy_d = 1'b1;
          if (period_end_c) begin
            div_cnt_d = '0;
            if (last_half_c) begin
              sclk_d  = cpol_q;
              state_d = ST_CS_HOLD;
            end else begin
              half_d = half_q + HALF_W'(1);
              sclk_d = ~sclk_q;
              // Even half ends on a trailing edge: present the next bit.
              if (!half_q[0]) begin
                if (lsb_q) begin
                  shreg_d = shreg_q >> 1;
                  sdo_d   = shreg_q[1];
                end else begin
                  shreg_d = shreg_q << 1;
                  sdo_d   = shreg_q[WORD_W-2];
                end
              end
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end

        ST_CS_HOLD: begin
          cs_d   = ctrl_sspol_q_i;
          sclk_d = cpol_q;
          busy_d = 1'b1;
          if (period_end_c) begin
            div_cnt_d = '0;
            state_d   = ST_IDLE;
            cs_d      = ~ctrl_sspol_q_i;
            sclk_d    = ctrl_cpol_q_i;
            sdo_d     = 1'b0;
            busy_d    = 1'b0;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      div_q        <= '0;
      half_q       <= '0;
      shreg_q      <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      cpol_q       <= 1'b0;
      lsb_q        <= 1'b0;
      dff_q        <= '0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      sdo_q        <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      div_q        <= div_d;
      half_q       <= half_d;
      shreg_q      <= shreg_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      cpol_q       <= cpol_d;
      lsb_q        <= lsb_d;
      dff_q        <= dff_d;
      sclk_q       <= sclk_d;
      cs_q         <= cs_d;
      sdo_q        <= sdo_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  assign spi_sclk_o = sclk_q;
  assign spi_cs_o   = cs_q;
  assign spi_sdo_o  = sdo_q;
  assign busy_o     = busy_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_wfg_drive_spi.sv
// Self-checking bench for wfg_drive_spi: scoreboard of accepted samples vs. serial output.
module tb_wfg_drive_spi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic       en;
  logic       cpol_r;
  logic       lsb_r;
  logic       sspol_r;
  logic [1:0] dff_r;
  logic [7:0] div_r;
  logic       sclk, cs, sdo, busy, underrun;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] word;
    int          n;
    bit          lsb;
  } exp_t;

  exp_t exp_q[$];

  wfg_drive_spi_if axis_if();

  wfg_drive_spi #(.DIV_W(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .axis              (axis_if),
    .wfg_sync_i        (sync),
    .ctrl_en_q_i       (en),
    .ctrl_cpol_q_i     (cpol_r),
    .ctrl_lsbfirst_q_i (lsb_r),
    .ctrl_sspol_q_i    (sspol_r),
    .ctrl_dff_q_i      (dff_r),
    .clkcfg_div_q_i    (div_r),
    .spi_sclk_o        (sclk),
    .spi_cs_o          (cs),
    .spi_sdo_o         (sdo),
    .busy_o            (busy),
    .underrun_o        (underrun)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic [17:0] s);
    exp_t e;
    e.n    = (int'(dff_r) + 1) * 8;
    e.word = {{14{s[17]}}, s};
    e.lsb  = lsb_r;
    return e;
  endfunction

  task automatic set_cfg(input logic [1:0] d, input bit l, input bit cp, input bit sp,
                         input logic [7:0] dv);
    dff_r = d; lsb_r = l; cpol_r = cp; sspol_r = sp; div_r = dv;
    repeat (3) @(negedge clk);
  endtask

  task automatic push_sample(input logic [17:0] s);
    int t = 0;
    @(negedge clk);
    axis_if.tvalid = 1'b1;
    axis_if.tdata  = s;
    while (axis_if.tready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 50) $display("FAIL push_timeout: tready stayed %b, required 1", axis_if.tready);
    if (t >= 50) n_err++;
    @(negedge clk);
    axis_if.tvalid = 1'b0;
    exp_q.push_back(make_exp(s));
  endtask

  // Pulse sync across one rising edge; returns at the negedge of cycle 1.
  task automatic pulse_sync();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  // Runs one transfer, checking timing and every bit against the scoreboard head.
  task automatic run_xfer(input bit mid_push, input logic [17:0] b_smp, input bit mid_sync);
    exp_t e;
    int hp, cyc, edges, cs_cycles, first_edge, idx;
    logic prev, bexp;
    bit done, saw_underrun;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: queue size %0d, required >0", exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    hp = int'(div_r) + 1;
    pulse_sync();
    cyc = 1; edges = 0; cs_cycles = 0; first_edge = -1;
    prev = cpol_r; done = 0; saw_underrun = 0;
    while (!done && cyc < 3000) begin
      if (underrun === 1'b1) saw_underrun = 1;
      if (cs === sspol_r) begin
        cs_cycles++;
        if (prev === cpol_r && sclk === ~cpol_r) begin
          edges++;
          if (first_edge < 0) first_edge = cyc;
          idx = edges - 1;
          if (idx < e.n) begin
            bexp = e.lsb ? e.word[idx] : e.word[e.n-1-idx];
            n_cmp++;
            if (sdo !== bexp) begin
              n_err++;
              $display("FAIL sdo_bit%0d: got %b expected %b (word %h)", idx, sdo, bexp, e.word);
            end
          end
        end
        prev = sclk;
      end else begin
        done = 1;
      end
      if (!done) begin
        if (mid_push && cyc == 10) begin
          n_cmp++;
          if (axis_if.tready !== 1'b1) begin
            n_err++;
            $display("FAIL tready_mid: got %b expected 1", axis_if.tready);
          end
          axis_if.tvalid = 1'b1;
          axis_if.tdata  = b_smp;
        end
        if (mid_push && cyc == 11) begin
          axis_if.tvalid = 1'b0;
          n_cmp++;
          if (axis_if.tready !== 1'b0) begin
            n_err++;
            $display("FAIL tready_full: got %b expected 0", axis_if.tready);
          end
          exp_q.push_back(make_exp(b_smp));
        end
        if (mid_sync && cyc == 14) sync = 1'b1;
        if (mid_sync && cyc == 15) sync = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL xfer_timeout: cs still active after %0d cycles", cyc);
    end
    n_cmp++;
    if (edges !== e.n) begin
      n_err++;
      $display("FAIL edge_count: got %0d expected %0d", edges, e.n);
    end
    n_cmp++;
    if (first_edge !== 1 + hp) begin
      n_err++;
      $display("FAIL first_edge: got cycle %0d expected %0d", first_edge, 1 + hp);
    end
    n_cmp++;
    if (cs_cycles !== (2 * e.n + 2) * hp) begin
      n_err++;
      $display("FAIL cs_window: got %0d expected %0d", cs_cycles, (2 * e.n + 2) * hp);
    end
    n_cmp++;
    if (busy !== 1'b0 || sclk !== cpol_r) begin
      n_err++;
      $display("FAIL idle_after: busy %b sclk %b expected busy 0 sclk %b", busy, sclk, cpol_r);
    end
    n_cmp++;
    if (saw_underrun) begin
      n_err++;
      $display("FAIL underrun_in_xfer: got 1 expected 0");
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({sclk, cs, sdo, busy, underrun, axis_if.tready} !== 6'b010000) begin
      n_err++;
      $display("FAIL reset_vals: got %b expected 010000",
               {sclk, cs, sdo, busy, underrun, axis_if.tready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (axis_if.tready !== 1'b1) begin
      n_err++;
      $display("FAIL tready_enabled: got %b expected 1", axis_if.tready);
    end
  endtask

  task automatic test_underrun();
    pulse_sync();
    n_cmp++;
    if ({underrun, cs, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL underrun_pulse: got %b expected 110", {underrun, cs, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({underrun, cs, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL underrun_single: got %b expected 010", {underrun, cs, busy});
    end
  endtask

  task automatic test_msb16();
    set_cfg(2'b01, 1'b0, 1'b0, 1'b0, 8'd0);
    push_sample(18'h1A5C3);
    run_xfer(1'b0, 18'h0, 1'b0);
  endtask

  task automatic test_lsb32();
    set_cfg(2'b11, 1'b1, 1'b1, 1'b0, 8'd3);
    n_cmp++;
    if (sclk !== 1'b1) begin
      n_err++;
      $display("FAIL sclk_idle_cpol1: got %b expected 1", sclk);
    end
    push_sample(18'h20001);
    run_xfer(1'b0, 18'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_cfg(2'b01, 1'b0, 1'b0, 1'b1, 8'd0);
    push_sample(18'h0F0F5);
    run_xfer(1'b1, 18'h3C3A9, 1'b1);
    n_cmp++;
    if (axis_if.tready !== 1'b0) begin
      n_err++;
      $display("FAIL tready_held: got %b expected 0", axis_if.tready);
    end
    repeat (2) @(negedge clk);
    run_xfer(1'b0, 18'h0, 1'b0);
  endtask

  task automatic test_abort();
    set_cfg(2'b00, 1'b0, 1'b0, 1'b0, 8'd1);
    push_sample(18'h000A5);
    pulse_sync();
    push_sample(18'h00033);
    repeat (12) @(negedge clk);
    n_cmp++;
    if ({busy, cs} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_pre: got %b expected 10", {busy, cs});
    end
    en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cs, sclk, sdo, axis_if.tready, busy, underrun} !== 6'b100000) begin
      n_err++;
      $display("FAIL abort_state: got %b expected 100000",
               {cs, sclk, sdo, axis_if.tready, busy, underrun});
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    pulse_sync();
    n_cmp++;
    if ({underrun, cs, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL abort_underrun: got %b expected 110", {underrun, cs, busy});
    end
  endtask

  task automatic test_reset_mid();
    bit stray = 0;
    set_cfg(2'b01, 1'b0, 1'b1, 1'b0, 8'd1);
    push_sample(18'h15555);
    pulse_sync();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sclk, cs, sdo, busy} !== 4'b0100) begin
      n_err++;
      $display("FAIL reset_mid: got %b expected 0100", {sclk, cs, sdo, busy});
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cs !== 1'b1 || busy !== 1'b0) stray = 1;
    end
    n_cmp++;
    if (stray) begin
      n_err++;
      $display("FAIL residual_xfer: got activity after reset release, expected none");
    end
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; en = 1'b0;
    cpol_r = 1'b0; lsb_r = 1'b0; sspol_r = 1'b0; dff_r = 2'b00; div_r = 8'd0;
    axis_if.tvalid = 1'b0;
    axis_if.tdata  = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_underrun();
    test_msb16();
    test_lsb32();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
